shift_iter: RTL and testbench

SHIFT_ITER -- requirements
Module: shift_iter

---
 rtl/shift_pkg.sv | 31 +++
 rtl/shift_stage.sv | 32 +++
 rtl/shift_iter.sv | 77 +++++++
 tb/tb_shift_iter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared encodings and sizing for the iterative shifter.
// Op 11 is a rotate-left only when SHIFT_ROTATE_EN is defined; otherwise it decodes as SHL.
package shift_pkg;

   localparam int DATA_W = 32;
   localparam int AMT_W  = 5;

   typedef enum logic [1:0] {
      OP_SHL = 2'b00,
      OP_SHR = 2'b01,
      OP_SAR = 2'b10,
      OP_ROL = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

   // Index of the highest set bit of the remaining distance (0 when none set).
   function automatic logic [2:0] top_bit(input logic [AMT_W-1:0] rem);
      logic [2:0] k;
      k = '0;
      for (int i = 0; i < AMT_W; i++) begin
         if (rem[i]) k = 3'(i);
      end
      return k;
   endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational shift stage: moves data by 2^k positions according to op.
// Rotate wrap logic exists only when SHIFT_ROTATE_EN is defined.
module shift_stage
   import shift_pkg::*;
(
   input  logic [DATA_W-1:0] i_data,
   input  logic [1:0]        i_op,
   input  logic [2:0]        i_k,
   output logic [DATA_W-1:0] o_data
);

   logic [5:0] w_dist;

   assign w_dist = 6'd1 << i_k;

   always_comb begin
      o_data = i_data << w_dist;
      case (op_e'(i_op))
         OP_SHL: o_data = i_data << w_dist;
         OP_SHR: o_data = i_data >> w_dist;
         // Sign bit stays put across stages, so repeated SAR keeps the original fill.
         OP_SAR: o_data = $unsigned($signed(i_data) >>> w_dist);
`ifdef SHIFT_ROTATE_EN
         OP_ROL: o_data = (i_data << w_dist) | (i_data >> (6'd32 - w_dist));
`else
         OP_ROL: o_data = i_data << w_dist;
`endif
         default: o_data = i_data << w_dist;
      endcase
   end

endmodule

// File: rtl/shift_iter.sv
// Iterative 32-bit shifter: one power-of-two stage per cycle, largest first, valid/ready on both sides.
// Optional rotate for op 11 is enabled by defining SHIFT_ROTATE_EN.
module shift_iter
   import shift_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [AMT_W-1:0]  amt,
   input  logic [1:0]        op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              busy
);

   state_e            r_state;
   state_e            w_state_next;
   logic [DATA_W-1:0] r_acc;
   logic [AMT_W-1:0]  r_rem;
   logic [1:0]        r_op;
   logic [2:0]        w_k;
   logic [AMT_W-1:0]  w_rem_clr;
   logic [DATA_W-1:0] w_stage_out;
   logic              w_accept;

   assign w_k       = top_bit(r_rem);
   assign w_rem_clr = r_rem & ~(AMT_W'(1) << w_k);
   assign w_accept  = in_valid && (r_state == ST_IDLE);

   shift_stage u_stage (
      .i_data (r_acc),
      .i_op   (r_op),
      .i_k    (w_k),
      .o_data (w_stage_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (in_valid) w_state_next = (amt == '0) ? ST_DONE : ST_SHIFT;
         ST_SHIFT: if (w_rem_clr == '0) w_state_next = ST_DONE;
         ST_DONE:  if (out_ready) w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == ST_IDLE);
      out_valid = (r_state == ST_DONE);
      busy      = (r_state != ST_IDLE);
      data_out  = r_acc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_rem <= '0;
         r_op  <= OP_SHL;
      end else if (w_accept) begin
         r_acc <= data_in;
         r_rem <= amt;
         r_op  <= op;
      end else if (r_state == ST_SHIFT) begin
         r_acc <= w_stage_out;
         r_rem <= w_rem_clr;
      end
   end

endmodule

// File: tb/tb_shift_iter.sv
// Self-checking bench for shift_iter: directed table, random ops vs. arithmetic model, corner sequences.
// Rotate expectations follow SHIFT_ROTATE_EN.
module tb_shift_iter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] data_in = '0;
   logic [4:0]  amt = '0;
   logic [1:0]  op = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] data_out;
   logic        busy;

   int checks = 0;
   int failures = 0;

   shift_iter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .amt       (amt),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [4:0]  a;
      logic [1:0]  o;
      logic [31:0] exp;
      string       name;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [31:0] d, input int a, input logic [1:0] o);
      case (o)
         2'b00: return d << a;
         2'b01: return d >> a;
         2'b10: return $unsigned($signed(d) >>> a);
         default: begin
`ifdef SHIFT_ROTATE_EN
            if (a == 0) return d;
            return (d << a) | (d >> (32 - a));
`else
            return d << a;
`endif
         end
      endcase
   endfunction

   // Present one operand, measure edges to out_valid, check result, then consume it.
   task automatic run_op(input logic [31:0] d, input logic [4:0] a, input logic [1:0] o,
                         input logic [31:0] exp, input string name);
      int lat;
      int exp_lat;
      exp_lat = 1 + $countones(a);
      @(negedge clk);
      chk({name, "/in_ready"}, {31'd0, in_ready}, 32'd1);
      data_in = d; amt = a; op = o; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      data_in = $urandom; amt = 5'($urandom); op = 2'($urandom);
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({name, "/latency"}, 32'(lat), 32'(exp_lat));
      chk({name, "/data_out"}, data_out, exp);
      $display("op d=%h amt=%0d op=%0d -> %h (lat %0d) %s", d, a, o, data_out, lat, name);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({name, "/idle_after"}, {31'd0, in_ready}, 32'd1);
   endtask

   vec_t vecs[8];

   initial begin
      logic [31:0] held;
      logic [31:0] rd;
      logic [4:0]  ra;
      logic [1:0]  ro;

      vecs[0] = '{32'h0000_0001, 5'd8,  2'b00, 32'h0000_0100, "shl_1_8"};
      vecs[1] = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, "sar_31"};
      vecs[2] = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, "shr_31"};
      vecs[3] = '{32'hFFFF_FFFF, 5'd0,  2'b00, 32'hFFFF_FFFF, "amt0_shl"};
      vecs[4] = '{32'hFFFF_FFFF, 5'd0,  2'b01, 32'hFFFF_FFFF, "amt0_shr"};
      vecs[5] = '{32'hFFFF_FFFF, 5'd0,  2'b10, 32'hFFFF_FFFF, "amt0_sar"};
      vecs[6] = '{32'hFFFF_FFFF, 5'd0,  2'b11, 32'hFFFF_FFFF, "amt0_rol"};
`ifdef SHIFT_ROTATE_EN
      vecs[7] = '{32'h8000_0001, 5'd1,  2'b11, 32'h0000_0003, "rol_1"};
`else
      vecs[7] = '{32'h8000_0001, 5'd1,  2'b11, 32'h0000_0002, "rol_as_shl_1"};
`endif

      // Reset state
      #2;
      chk("rst/in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst/out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst/busy", {31'd0, busy}, 32'd0);
      chk("rst/data_out", data_out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_op(vecs[i].d, vecs[i].a, vecs[i].o, vecs[i].exp, vecs[i].name);

      for (int n = 0; n < 40; n++) begin
         rd = $urandom;
         ra = 5'($urandom);
         ro = 2'($urandom);
         run_op(rd, ra, ro, ref_shift(rd, int'(ra), ro), "random");
      end

      // Backpressure: result and handshake outputs hold, input pulses are ignored
      @(negedge clk);
      data_in = 32'h1234_5678; amt = 5'd4; op = 2'b01; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int w = 0; w < 10 && !out_valid; w++) begin
         @(posedge clk);
         #1;
      end
      held = data_out;
      chk("bp/result", held, 32'h0123_4567);
      for (int c = 0; c < 5; c++) begin
         data_in = $urandom; amt = 5'($urandom); in_valid = c[0];
         @(posedge clk);
         #1;
         chk("bp/data_out", data_out, held);
         chk("bp/out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp/in_ready", {31'd0, in_ready}, 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp/released", {31'd0, in_ready}, 32'd1);
      $display("backpressure held %h", held);

      // Reset mid-SHIFT
      @(negedge clk);
      data_in = 32'hDEAD_BEEF; amt = 5'd31; op = 2'b00; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst/busy_before", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst/busy", {31'd0, busy}, 32'd0);
      chk("midrst/in_ready", {31'd0, in_ready}, 32'd1);
      chk("midrst/out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst/data_out", data_out, 32'd0);
      $display("reset mid-shift applied");
      @(negedge clk);
      rst_n = 1'b1;
      run_op(32'hF000_000F, 5'd3, 2'b10, 32'hFE00_0001, "after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
